// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle MIPS sequencing controller.
// Holds the state enum, opcode/funct constants and datapath mux/ALU codes.
package mc_pkg;
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
      ALUWB, BRANCH, IMMEX, IMMWB, JUMP, JAL, TRAP
   } state_t;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] F_ADD    = 6'b100000;
   localparam logic [5:0] F_ADDU   = 6'b100001;
   localparam logic [5:0] F_SUB    = 6'b100010;
   localparam logic [5:0] F_SUBU   = 6'b100011;
   localparam logic [5:0] F_AND    = 6'b100100;
   localparam logic [5:0] F_OR     = 6'b100101;
   localparam logic [5:0] F_SLT    = 6'b101010;
   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_4     = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: R-type funct to ALU control decode; legal_o flags supported functs.
module mc_aludec
   import mc_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [2:0] alucontrol_o,
   output logic       legal_o
);
   always_comb begin
      alucontrol_o = 3'bxxx;
      legal_o = 1'b1;
      case (funct_i)
         F_ADD, F_ADDU: alucontrol_o = ALU_ADD;
         F_SUB, F_SUBU: alucontrol_o = ALU_SUB;
         F_AND:         alucontrol_o = ALU_AND;
         F_OR:          alucontrol_o = ALU_OR;
         F_SLT:         alucontrol_o = ALU_SLT;
         default:       legal_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS sequencer for a shared instruction/data memory.
// Define MC_ILLEGAL_TRAP_EN to trap on unknown opcodes / functs instead of NOPing.
module mc_controller
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcen,
   output logic [1:0] pcsrc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucontrol,
   output logic       signext,
   output logic       shiftl16,
   output logic       regdst,
   output logic       memtoreg,
   output logic       isjal,
   output logic       regwrite,
   output logic       trap
);
`ifdef MC_ILLEGAL_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif
   state_t state_q, state_d;
   logic [2:0] alu_r;
   logic       funct_ok;
   mc_aludec u_aludec (
      .funct_i      (funct),
      .alucontrol_o (alu_r),
      .legal_o      (funct_ok)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW:                        state_d = MEMADR;
               OP_RTYPE:                            state_d = (funct_ok || !TRAP_EN) ? EXEC : TRAP;
               OP_BEQ, OP_BNE:                      state_d = BRANCH;
               OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI:   state_d = IMMEX;
               OP_J:                                state_d = JUMP;
               OP_JAL:                              state_d = JAL;
               default:                             state_d = TRAP_EN ? TRAP : FETCH;
            endcase
         end
         MEMADR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
         MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
         EXEC:   state_d = ALUWB;
         IMMEX:  state_d = IMMWB;
         TRAP:   state_d = TRAP_EN ? TRAP : FETCH;
         default: state_d = FETCH;
      endcase
   end
   // Outputs are forced low while reset is held so an in-flight write is dropped at once.
   always_comb begin
      mem_req = 1'b0;
      iord = 1'b0;
      memwrite = 1'b0;
      irwrite = 1'b0;
      pcen = 1'b0;
      pcsrc = PC_ALU;
      alusrca = 1'b0;
      alusrcb = SRCB_B;
      alucontrol = ALU_AND;
      signext = 1'b0;
      shiftl16 = 1'b0;
      regdst = 1'b0;
      memtoreg = 1'b0;
      isjal = 1'b0;
      regwrite = 1'b0;
      trap = 1'b0;
      if (reset) begin
         case (state_q)
            FETCH: begin
               mem_req = 1'b1;
               alusrcb = SRCB_4;
               alucontrol = ALU_ADD;
               irwrite = mem_ready;
               pcen = mem_ready;
            end
            DECODE: begin
               alusrcb = SRCB_IMMSH;
               signext = 1'b1;
               alucontrol = ALU_ADD;
            end
            MEMADR: begin
               alusrca = 1'b1;
               alusrcb = SRCB_IMM;
               signext = 1'b1;
               alucontrol = ALU_ADD;
            end
            MEMRD: begin
               mem_req = 1'b1;
               iord = 1'b1;
            end
            MEMWB: begin
               memtoreg = 1'b1;
               regwrite = 1'b1;
            end
            MEMWR: begin
               mem_req = 1'b1;
               iord = 1'b1;
               memwrite = 1'b1;
            end
            EXEC: begin
               alusrca = 1'b1;
               alucontrol = alu_r;
            end
            ALUWB: begin
               regdst = 1'b1;
               regwrite = 1'b1;
            end
            BRANCH: begin
               alusrca = 1'b1;
               alucontrol = ALU_SUB;
               pcsrc = PC_ALUOUT;
               pcen = zero ^ (op == OP_BNE);
            end
            IMMEX, IMMWB: begin
               alusrca = 1'b1;
               alusrcb = SRCB_IMM;
               signext = (op == OP_ADDI) || (op == OP_ADDIU);
               shiftl16 = (op == OP_LUI);
               alucontrol = (op == OP_ORI) ? ALU_OR : ALU_ADD;
               regwrite = (state_q == IMMWB);
            end
            JUMP: begin
               pcsrc = PC_JUMP;
               pcen = 1'b1;
            end
            JAL: begin
               pcsrc = PC_JUMP;
               pcen = 1'b1;
               isjal = 1'b1;
               regwrite = 1'b1;
            end
            TRAP: trap = TRAP_EN;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench; an instruction-level model queues the expected
// output vector of every active cycle and a negedge monitor pops and compares them.
module tb_mc_controller;
   import mc_pkg::*;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] op = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, iord, memwrite, irwrite, pcen, alusrca;
   logic [1:0] pcsrc, alusrcb;
   logic [2:0] alucontrol;
   logic       signext, shiftl16, regdst, memtoreg, isjal, regwrite, trap;
   typedef struct packed {
      logic       mem_req, iord, memwrite, irwrite, pcen;
      logic [1:0] pcsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alucontrol;
      logic       signext, shiftl16, regdst, memtoreg, isjal, regwrite, trap;
   } outs_t;
   typedef struct { int cyc; outs_t v; } ev_t;
   typedef struct { logic [5:0] op; logic [5:0] funct; logic zero; int start; } ins_t;
   outs_t act;
   ev_t   exq[$];
   ins_t  iq[$];
   int    wq[$];
   ev_t   cur;
   int    t, cyc, errors, checks, wleft;
   bit    run, in_acc;
   logic [5:0] ops[12] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
                           OP_ORI, OP_LUI, OP_J, OP_JAL, 6'b111111};
   logic [5:0] fns[7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a};

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
      .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
      .signext(signext), .shiftl16(shiftl16), .regdst(regdst), .memtoreg(memtoreg),
      .isjal(isjal), .regwrite(regwrite), .trap(trap)
   );
   assign act = {mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb, alucontrol,
                 signext, shiftl16, regdst, memtoreg, isjal, regwrite, trap};

   always #5 clk = ~clk;

   function automatic outs_t fetch_o(logic done);
      outs_t e = '0;
      e.mem_req = 1'b1;
      e.alusrcb = 2'b01;
      e.alucontrol = 3'b010;
      e.irwrite = done;
      e.pcen = done;
      return e;
   endfunction

   function automatic logic [2:0] alu_of(logic [5:0] f);
      case (f)
         6'h20, 6'h21: return 3'b010;
         6'h22, 6'h23: return 3'b110;
         6'h24:        return 3'b000;
         6'h25:        return 3'b001;
         default:      return 3'b111;
      endcase
   endfunction

   function automatic void push(int c, outs_t v);
      exq.push_back('{c, v});
   endfunction

   // Expands one instruction into its per-cycle expected outputs from the latency rules.
   function automatic void add_instr(logic [5:0] o, logic [5:0] f, logic z, int wf, int wm);
      outs_t e;
      int d;
      for (int i = 0; i < wf; i++) push(t + i, fetch_o(1'b0));
      push(t + wf, fetch_o(1'b1));
      wq.push_back(wf);
      iq.push_back('{o, f, z, t});
      d = t + wf + 1;
      e = '0; e.alusrcb = 2'b11; e.signext = 1'b1; e.alucontrol = 3'b010;
      push(d, e);
      e = '0;
      if (o == OP_RTYPE) begin
         e.alusrca = 1'b1; e.alucontrol = alu_of(f);
         push(d + 1, e);
         e = '0; e.regdst = 1'b1; e.regwrite = 1'b1;
         push(d + 2, e);
         t = d + 3;
      end else if (o == OP_LW || o == OP_SW) begin
         e.alusrca = 1'b1; e.alusrcb = 2'b10; e.signext = 1'b1; e.alucontrol = 3'b010;
         push(d + 1, e);
         e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = (o == OP_SW);
         for (int i = 0; i <= wm; i++) push(d + 2 + i, e);
         wq.push_back(wm);
         if (o == OP_LW) begin
            e = '0; e.memtoreg = 1'b1; e.regwrite = 1'b1;
            push(d + 3 + wm, e);
            t = d + 4 + wm;
         end else t = d + 3 + wm;
      end else if (o == OP_BEQ || o == OP_BNE) begin
         e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z ^ (o == OP_BNE);
         push(d + 1, e);
         t = d + 2;
      end else if (o == OP_ADDI || o == OP_ADDIU || o == OP_ORI || o == OP_LUI) begin
         e.alusrca = 1'b1; e.alusrcb = 2'b10;
         e.signext = (o == OP_ADDI || o == OP_ADDIU);
         e.shiftl16 = (o == OP_LUI);
         e.alucontrol = (o == OP_ORI) ? 3'b001 : 3'b010;
         push(d + 1, e);
         e.regwrite = 1'b1;
         push(d + 2, e);
         t = d + 3;
      end else if (o == OP_J || o == OP_JAL) begin
         e.pcsrc = 2'b10; e.pcen = 1'b1; e.isjal = (o == OP_JAL); e.regwrite = (o == OP_JAL);
         push(d + 1, e);
         t = d + 2;
      end else begin
`ifdef MC_ILLEGAL_TRAP_EN
         e.trap = 1'b1;
         for (int i = 0; i < 5; i++) push(d + 1 + i, e);
         t = d + 6;
`else
         t = d + 1;
`endif
      end
   endfunction

   task automatic chk(string name, outs_t a, outs_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, a, e);
      end
   endtask

   // Driver, memory responder and monitor share one process so drive precedes sampling.
   always @(negedge clk) begin
      if (reset && run) begin
         if (iq.size() != 0 && iq[0].start == cyc) begin
            op = iq[0].op;
            funct = iq[0].funct;
            zero = iq[0].zero;
            void'(iq.pop_front());
         end
         if (!mem_req) begin
            in_acc = 1'b0;
            mem_ready = 1'($urandom);
         end else begin
            if (!in_acc) begin
               in_acc = 1'b1;
               wleft = (wq.size() != 0) ? wq.pop_front() : 0;
            end
            if (wleft > 0) begin
               mem_ready = 1'b0;
               wleft--;
            end else begin
               mem_ready = 1'b1;
               in_acc = 1'b0;
            end
         end
         #1;
         while (exq.size() != 0 && exq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_output cyc=%0d got=none want=%h", exq[0].cyc, exq[0].v);
            void'(exq.pop_front());
         end
         if (act != '0) begin
            checks++;
            if (exq.size() == 0) begin
               errors++;
               $display("FAIL extra_output cyc=%0d got=%h want=none", cyc, act);
            end else begin
               cur = exq.pop_front();
               if (cur.cyc != cyc || cur.v !== act) begin
                  errors++;
                  $display("FAIL cycle_output cyc=%0d got=%h want=%h at cyc=%0d", cyc, act, cur.v, cur.cyc);
               end
            end
         end
         cyc++;
      end
   end

   initial begin
      outs_t e;
      errors = 0; checks = 0; run = 1'b0; in_acc = 1'b0; wleft = 0; t = 0; cyc = 0;
      repeat (2) @(posedge clk);
      #1 chk("outputs_in_reset", act, '0);
      op = OP_SW; mem_ready = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      chk("fetch_after_release", act, fetch_o(1'b1));
      @(posedge clk);
      #1 mem_ready = 1'b0;
      for (int i = 0; i < 10 && !memwrite; i++) @(negedge clk);
      e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = 1'b1;
      chk("memwr_reached", act, e);
      @(negedge clk);
      chk("memwr_held_while_waiting", act, e);
      reset = 1'b0;
      #1 chk("async_reset_mid_write", act, '0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("fetch_wait_after_reset", act, fetch_o(1'b0));
      reset = 1'b0;
      repeat (2) @(posedge clk);
      t = 0;
      add_instr(OP_RTYPE, 6'h20, 1'b0, 0, 0);
      add_instr(OP_LW, 6'h00, 1'b0, 2, 1);
      add_instr(OP_BEQ, 6'h00, 1'b1, 0, 0);
      add_instr(OP_BNE, 6'h00, 1'b1, 0, 0);
      add_instr(OP_JAL, 6'h00, 1'b0, 0, 0);
      add_instr(OP_SW, 6'h00, 1'b0, 0, 2);
      for (int k = 0; k < 150; k++) begin
`ifdef MC_ILLEGAL_TRAP_EN
         int idx = $urandom_range(0, 10);
`else
         int idx = $urandom_range(0, 11);
`endif
         add_instr(ops[idx], (ops[idx] == OP_RTYPE) ? fns[$urandom_range(0, 6)] : 6'($urandom),
                   1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end
      add_instr(6'b111111, 6'h00, 1'b0, 0, 0);
      #1 reset = 1'b1;
      cyc = 0;
      run = 1'b1;
      for (int i = 0; i < t + 100 && cyc < t; i++) @(posedge clk);
      #1 run = 1'b0;
      checks++;
      if (exq.size() != 0 || iq.size() != 0) begin
         errors++;
         $display("FAIL leftover_expected got=%0d pending want=0", exq.size() + iq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
